// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: accepts a multi-hot request vector on a valid/ready
// handshake and serialises the index of every set bit, one per output beat.
`default_nettype none

module priority_scan_encoder #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         iv_input,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(WIDTH)-1:0] ov_addr,
  output logic                     o_last,
  output logic                     o_zero
);

  localparam int ADDR_WIDTH = $clog2(WIDTH);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SCAN = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [WIDTH-1:0]      pend;
  logic [WIDTH-1:0]      pend_next;
  logic                  zero_q;
  logic                  zero_next;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic                  one_hot;
  logic                  accept;
  logic                  beat;

  // Priority encode of the pending register; the last match in scan order wins.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        top_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (pend[i]) top_idx = ADDR_WIDTH'(i);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        top_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (pend[i]) top_idx = ADDR_WIDTH'(i);
        end
      end
    end
  endgenerate

  assign one_hot = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= STATE_IDLE;
      pend   <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_next;
      pend   <= pend_next;
      zero_q <= zero_next;
    end
  end

  always_comb begin
    accept    = i_valid & o_ready;
    beat      = o_valid & i_ready;
    pend_next = pend;
    if (beat) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (top_idx == ADDR_WIDTH'(i)) pend_next[i] = 1'b0;
      end
    end
    // Accept is only possible when pend is empty or its last bit is leaving.
    if (accept) pend_next = iv_input;
    zero_next  = accept && (iv_input == '0);
    state_next = (pend_next != '0) ? STATE_SCAN : STATE_IDLE;
  end

  always_comb begin
    o_valid = (state == STATE_SCAN);
    ov_addr = o_valid ? top_idx : '0;
    o_last  = o_valid & one_hot;
    o_ready = (state == STATE_IDLE) | (o_valid & i_ready & o_last);
    o_zero  = zero_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder: four encoder configurations share one stimulus
// stream and are checked against a per-instance queue of expected indices.
`default_nettype none

module tb_priority_scan_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       dn_ready = 1'b0;
  logic [7:0] vec = 8'h00;

  logic [3:0] rdy_o;
  logic [3:0] val_o;
  logic [3:0] last_o;
  logic [3:0] zero_o;
  logic [2:0] addr_o [4];
  logic       addr_w2;

  int checks   = 0;
  int failures = 0;

  int wid [4] = '{5, 5, 2, 8};
  bit msb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  int exp_q [4][$];
  bit zero_exp [4];

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_o[0]),
    .iv_input(vec[4:0]), .o_valid(val_o[0]), .i_ready(dn_ready),
    .ov_addr(addr_o[0]), .o_last(last_o[0]), .o_zero(zero_o[0]));

  priority_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_o[1]),
    .iv_input(vec[4:0]), .o_valid(val_o[1]), .i_ready(dn_ready),
    .ov_addr(addr_o[1]), .o_last(last_o[1]), .o_zero(zero_o[1]));

  priority_scan_encoder #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_o[2]),
    .iv_input(vec[1:0]), .o_valid(val_o[2]), .i_ready(dn_ready),
    .ov_addr(addr_w2), .o_last(last_o[2]), .o_zero(zero_o[2]));

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_o[3]),
    .iv_input(vec), .o_valid(val_o[3]), .i_ready(dn_ready),
    .ov_addr(addr_o[3]), .o_last(last_o[3]), .o_zero(zero_o[3]));

  assign addr_o[2] = {2'b00, addr_w2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats of a vector: every set bit below the width, in priority order.
  task automatic push_vector(input int k, input logic [7:0] v, output bit is_zero);
    is_zero = 1'b1;
    for (int n = 0; n < wid[k]; n++) begin
      int i;
      i = msb[k] ? (wid[k] - 1 - n) : n;
      if (v[i]) begin
        exp_q[k].push_back(i);
        is_zero = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      zero_exp[k] = 1'b0;
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 time unit
  // later, then the model advances for the coming rising edge.
  task automatic step();
    #1;
    for (int k = 0; k < 4; k++) begin
      bit exp_ready;
      bit zero_new;
      bit is_zero;
      check($sformatf("u%0d_zero", k), zero_o[k], zero_exp[k]);
      check($sformatf("u%0d_valid", k), val_o[k], exp_q[k].size() != 0);
      if (exp_q[k].size() != 0) begin
        check($sformatf("u%0d_addr", k), addr_o[k], exp_q[k][0]);
        check($sformatf("u%0d_last", k), last_o[k], exp_q[k].size() == 1);
      end else begin
        check($sformatf("u%0d_addr_idle", k), addr_o[k], 0);
        check($sformatf("u%0d_last_idle", k), last_o[k], 0);
      end
      exp_ready = (exp_q[k].size() == 0) || (exp_q[k].size() == 1 && dn_ready);
      check($sformatf("u%0d_ready", k), rdy_o[k], exp_ready);
      zero_new = 1'b0;
      if (!rst) begin
        if (exp_q[k].size() != 0 && dn_ready) void'(exp_q[k].pop_front());
        if (valid && exp_ready) begin
          push_vector(k, vec, is_zero);
          zero_new = is_zero;
        end
      end
      zero_exp[k] = zero_new;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    valid    = v;
    vec      = d;
    dn_ready = r;
    step();
  endtask

  initial begin
    clear_model();
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);

    // Basic scan of 10110 in both orders.
    drive(1'b1, 8'b10110, 1'b1);
    for (int n = 0; n < 4; n++) drive(1'b0, 8'h00, 1'b1);

    // All-zero vector.
    drive(1'b1, 8'h00, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b0, 8'h00, 1'b1);

    // Stall on the first beat while a different vector is offered.
    drive(1'b1, 8'b01001, 1'b0);
    for (int n = 0; n < 3; n++) drive(1'b1, 8'b11111, 1'b0);
    for (int n = 0; n < 3; n++) drive(1'b0, 8'h00, 1'b1);

    // Back-to-back vectors with the second one presented on the last beat.
    drive(1'b1, 8'b00001, 1'b1);
    drive(1'b1, 8'b10000, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a scan.
    drive(1'b1, 8'b11111, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    clear_model();
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    drive(1'b1, 8'b00100, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b0, 8'h00, 1'b1);

    // Randomised sweep with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      drive($urandom_range(0, 1) == 1, d, $urandom_range(0, 9) < 7);
    end
    for (int n = 0; n < 12; n++) drive(1'b0, 8'h00, 1'b1);

    for (int k = 0; k < 4; k++)
      check($sformatf("u%0d_drained", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
- Sequential, parametrised successor to the combinational binary priority encoder.
- Accepts a WIDTH-bit request vector on a valid/ready handshake and holds it in a pending register.
- Emits the index of every set bit, one index per accepted output beat, in priority order. MSB-first is the default, matching the existing encoder; LSB-first is selectable.
- Used wherever a multi-hot vector must be serialised into addresses, e.g. interrupt or request draining in front of a single-port consumer.

Parameters:
- WIDTH, 5, request vector width; must be >= 2. ADDR_WIDTH = $clog2(WIDTH) is a derived localparam.
- MSB_FIRST, 1, 1: highest set index is emitted first; 0: lowest set index is emitted first.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_valid  input  1  iv_input is valid.
- o_ready  output  1  block can accept a new vector this cycle.
- iv_input  input  WIDTH  request vector.
- o_valid  output  1  ov_addr holds a valid index.
- i_ready  input  1  downstream accepts ov_addr this cycle.
- ov_addr  output  ADDR_WIDTH  index of the current highest-priority pending bit.
- o_last  output  1  current beat is the final set bit of the vector.
- o_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (async assert, sync release):
  - pending = 0, state = IDLE.
  - o_valid = 0, o_zero = 0, o_last = 0, ov_addr = 0, o_ready = 1.
  - Reset mid-scan discards all pending bits; no further beats are emitted.
- State: pending register pv[WIDTH-1:0]. FSM states are IDLE (pv == 0) and SCAN (pv != 0). o_valid = (state == SCAN).
- Input accept:
  - accept = i_valid & o_ready.
  - o_ready = IDLE | (o_valid & i_ready & o_last), so a new vector can be accepted in the same cycle the last beat leaves. No bubble between vectors.
- On accept of a nonzero vector: pv <= iv_input and state <= SCAN. o_valid rises the next cycle, so latency from accept to first beat is 1 cycle.
- On accept of an all-zero vector: pv stays 0, state = IDLE, and o_zero = 1 for exactly the next cycle. No o_valid is produced.
- Output values:
  - ov_addr is the priority encode of pv: the highest set index when MSB_FIRST=1, the lowest when MSB_FIRST=0.
  - ov_addr is driven from registers only. There is no combinational path from iv_input or i_valid to ov_addr or o_valid.
  - ov_addr = 0 whenever o_valid = 0.
- o_last = 1 iff pv is one-hot (exactly one bit set) and o_valid = 1.
- Beat transfer (o_valid & i_ready):
  - The bit at ov_addr is cleared in pv.
  - If o_last is set and there is no simultaneous accept, the next state is IDLE.
  - If o_last is set and a simultaneous accept occurs, pv <= iv_input (or IDLE + o_zero pulse if iv_input = 0).
- Backpressure: while o_valid & ~i_ready, pv, ov_addr and o_last hold stable. iv_input is ignored because o_ready = 0.
- Indices >= WIDTH are never emitted. When WIDTH is not a power of two, unused ov_addr codes never appear.
- Throughput: one index per cycle with i_ready held high. A vector with k set bits completes in k cycles after the first beat.

Test Plan:
- WIDTH=5, MSB_FIRST=1, i_ready=1; accept 5'b10110 -> beats ov_addr 4, 2, 1 on consecutive cycles starting 1 cycle after accept; o_last only on the addr=1 beat; o_ready=1 again on that beat.
- MSB_FIRST=0, same vector -> ov_addr 1, 2, 4; o_last on 4.
- Accept 5'b00000 -> o_zero high for exactly one cycle, o_valid never rises, o_ready stays 1.
- 5'b01001 with i_ready low for 3 cycles on the first beat -> ov_addr=3, o_last=0 held stable; then beats 3, 0; iv_input changes during the stall are ignored.
- Back-to-back: 5'b00001 then 5'b10000 presented on the last-beat cycle -> ov_addr 0 (last), next cycle 4 (last), no idle cycle between.
- Assert i_rst mid-scan of 5'b11111 after two beats -> o_valid drops immediately, o_ready=1; after release, accept 5'b00100 -> single beat ov_addr=2, o_last=1.
- WIDTH=2 and WIDTH=8 sweeps: random vectors checked against a reference model for index order, beat count = popcount, and o_last placement.
